// File: rtl/dft_pkg.sv
// Shared types and helpers for the single-engine DFT bin scheduler.
package dft_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultMaxN  = 16;

  // Scheduler states; StIdle must stay at encoding zero.
  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StEngRst,
    StFeed,
    StGap,
    StWaitDone,
    StOut
  } state_e;

  // Bin index for bin counter j, wrapped into 0..n-1.
  function automatic int unsigned k_wrap(input int unsigned k_first,
                                         input int unsigned j,
                                         input int unsigned n);
    return (n == 32'd0) ? 32'd0 : (k_first + j) % n;
  endfunction

endpackage

// File: rtl/dft_sample_buf.sv
// Frame sample store: one write port, one combinational read port.
module dft_sample_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage; reset wipes the frame so stale samples never reach the engine.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dft_bin_scheduler.sv
// Time-shares one single-bin DFT engine across a run of bins of one frame.
module dft_bin_scheduler
  import dft_pkg::*;
#(
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned MAX_N        = DefaultMaxN,
  parameter int unsigned WR_GAP       = 16,
  parameter int unsigned DONE_TIMEOUT = 1024
) (
  input  logic                    i_sys_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [WIDTH-1:0]        i_N,
  input  logic [WIDTH-1:0]        i_k_first,
  input  logic [WIDTH-1:0]        i_k_count,
  input  logic signed [WIDTH-1:0] i_x,
  input  logic                    i_x_valid,
  output logic                    o_x_ready,
  output logic                    o_eng_reset,
  output logic [WIDTH-1:0]        o_eng_x,
  output logic                    o_eng_wr,
  output logic [WIDTH-1:0]        o_eng_k,
  output logic [WIDTH-1:0]        o_eng_n,
  output logic [WIDTH-1:0]        o_eng_N,
  input  logic signed [WIDTH-1:0] i_eng_X_re,
  input  logic signed [WIDTH-1:0] i_eng_X_im,
  input  logic                    i_eng_done,
  output logic [WIDTH-1:0]        o_X_re,
  output logic [WIDTH-1:0]        o_X_im,
  output logic [WIDTH-1:0]        o_k,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy,
  output logic                    o_err
);

  localparam int unsigned AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  // Gap counter runs 0..WR_GAP-2; timeout counter runs 0..DONE_TIMEOUT-1.
  localparam int unsigned GW = (WR_GAP > 2) ? $clog2(WR_GAP) : 1;
  localparam int unsigned TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;

  state_e state_q, state_d;

  logic [WIDTH-1:0] frame_n_q, frame_n_d;
  logic [WIDTH-1:0] k_first_q, k_first_d;
  logic [WIDTH-1:0] k_count_q, k_count_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] eng_x_q, eng_x_d;
  logic [WIDTH-1:0] eng_k_q, eng_k_d;
  logic [WIDTH-1:0] eng_n_q, eng_n_d;
  logic [WIDTH-1:0] eng_len_q, eng_len_d;
  logic [WIDTH-1:0] x_re_q, x_re_d;
  logic [WIDTH-1:0] x_im_q, x_im_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;

  logic             buf_we;
  logic [AW-1:0]    buf_raddr;
  logic [WIDTH-1:0] buf_rdata;
  logic [WIDTH-1:0] eng_n_next;

  assign eng_n_next = eng_n_q + WIDTH'(1);

  dft_sample_buf #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_N)
  ) u_buf (
    .clk_i   (i_sys_clk),
    .rst_i   (i_reset),
    .we_i    (buf_we),
    .waddr_i (AW'(cnt_q)),
    .wdata_i (i_x),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  // Next-state and datapath updates; engine drive registers are loaded on the
  // transition into the state that uses them so they are stable for its whole span.
  always_comb begin
    state_d   = state_q;
    frame_n_d = frame_n_q;
    k_first_d = k_first_q;
    k_count_d = k_count_q;
    cnt_d     = cnt_q;
    j_d       = j_q;
    eng_x_d   = eng_x_q;
    eng_k_d   = eng_k_q;
    eng_n_d   = eng_n_q;
    eng_len_d = eng_len_q;
    x_re_d    = x_re_q;
    x_im_d    = x_im_q;
    k_d       = k_q;
    gap_d     = gap_q;
    tmo_d     = tmo_q;
    err_d     = 1'b0;
    buf_we    = 1'b0;
    // Sample 0 feeds the first write of a bin; otherwise prefetch the next one.
    buf_raddr = (state_q == StGap) ? AW'(eng_n_next) : '0;

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if ((i_N == '0) || (32'(i_N) > MAX_N)) begin
            err_d = 1'b1;
          end else begin
            frame_n_d = i_N;
            k_first_d = i_k_first;
            k_count_d = i_k_count;
            cnt_d     = '0;
            state_d   = StLoad;
          end
        end
      end
      StLoad: begin
        if (i_x_valid) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + WIDTH'(1);
          if (cnt_q == frame_n_q - WIDTH'(1)) begin
            j_d = '0;
            if (k_count_q == '0) begin
              state_d = StIdle;
            end else begin
              eng_k_d   = WIDTH'(k_wrap(32'(k_first_q), 32'd0, 32'(frame_n_q)));
              eng_len_d = frame_n_q;
              state_d   = StEngRst;
            end
          end
        end
      end
      StEngRst: begin
        eng_n_d = '0;
        eng_x_d = buf_rdata;
        state_d = StFeed;
      end
      StFeed: begin
        gap_d   = '0;
        state_d = StGap;
      end
      StGap: begin
        if (gap_q == GW'(WR_GAP - 2)) begin
          if (eng_n_next < frame_n_q) begin
            eng_n_d = eng_n_next;
            eng_x_d = buf_rdata;
            state_d = StFeed;
          end else begin
            tmo_d   = '0;
            state_d = StWaitDone;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      StWaitDone: begin
        if (i_eng_done) begin
          x_re_d  = i_eng_X_re;
          x_im_d  = i_eng_X_im;
          k_d     = eng_k_q;
          state_d = StOut;
        end else if (tmo_q == TW'(DONE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StOut: begin
        if (i_ready) begin
          j_d = j_q + WIDTH'(1);
          if ((j_q + WIDTH'(1)) < k_count_q) begin
            eng_k_d   = WIDTH'(k_wrap(32'(k_first_q), 32'(j_q) + 32'd1, 32'(frame_n_q)));
            eng_len_d = frame_n_q;
            state_d   = StEngRst;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      frame_n_q <= '0;
      k_first_q <= '0;
      k_count_q <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      eng_x_q   <= '0;
      eng_k_q   <= '0;
      eng_n_q   <= '0;
      eng_len_q <= '0;
      x_re_q    <= '0;
      x_im_q    <= '0;
      k_q       <= '0;
      gap_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_n_q <= frame_n_d;
      k_first_q <= k_first_d;
      k_count_q <= k_count_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      eng_x_q   <= eng_x_d;
      eng_k_q   <= eng_k_d;
      eng_n_q   <= eng_n_d;
      eng_len_q <= eng_len_d;
      x_re_q    <= x_re_d;
      x_im_q    <= x_im_d;
      k_q       <= k_d;
      gap_q     <= gap_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
    end
  end

  // Outputs are masked while reset is held so the engine sees only its reset.
  assign o_eng_reset = i_reset || (state_q == StEngRst);
  assign o_eng_wr    = !i_reset && (state_q == StFeed);
  assign o_x_ready   = !i_reset && (state_q == StLoad);
  assign o_valid     = !i_reset && (state_q == StOut);
  assign o_busy      = !i_reset && (state_q != StIdle);
  assign o_err       = !i_reset && err_q;
  assign o_eng_x     = i_reset ? '0 : eng_x_q;
  assign o_eng_k     = i_reset ? '0 : eng_k_q;
  assign o_eng_n     = i_reset ? '0 : eng_n_q;
  assign o_eng_N     = i_reset ? '0 : eng_len_q;
  assign o_X_re      = i_reset ? '0 : x_re_q;
  assign o_X_im      = i_reset ? '0 : x_im_q;
  assign o_k         = i_reset ? '0 : k_q;

endmodule

// File: tb/tb_dft_bin_scheduler.sv
// Directed bench for dft_bin_scheduler with a behavioural 4-point engine.
module tb_dft_bin_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   i_reset, i_start, i_x_valid, i_ready, i_eng_done;
  logic [7:0]             i_N, i_k_first, i_k_count;
  logic signed [7:0]      i_x, i_eng_X_re, i_eng_X_im;
  logic                   o_x_ready, o_eng_reset, o_eng_wr, o_valid, o_busy, o_err;
  logic [7:0]             o_eng_x, o_eng_k, o_eng_n, o_eng_N, o_X_re, o_X_im, o_k;

  dft_bin_scheduler dut (
    .i_sys_clk   (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_N         (i_N),
    .i_k_first   (i_k_first),
    .i_k_count   (i_k_count),
    .i_x         (i_x),
    .i_x_valid   (i_x_valid),
    .o_x_ready   (o_x_ready),
    .o_eng_reset (o_eng_reset),
    .o_eng_x     (o_eng_x),
    .o_eng_wr    (o_eng_wr),
    .o_eng_k     (o_eng_k),
    .o_eng_n     (o_eng_n),
    .o_eng_N     (o_eng_N),
    .i_eng_X_re  (i_eng_X_re),
    .i_eng_X_im  (i_eng_X_im),
    .i_eng_done  (i_eng_done),
    .o_X_re      (o_X_re),
    .o_X_im      (o_X_im),
    .o_k         (o_k),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural engine: 4-point twiddles, done held once all N writes arrived.
  logic signed [15:0] acc_re = '0, acc_im = '0, xv;
  int  wr_seen = 0;
  bit  done_en;
  assign xv = 16'($signed(o_eng_x));
  always @(posedge clk) begin
    if (o_eng_reset) begin
      acc_re  <= '0;
      acc_im  <= '0;
      wr_seen <= 0;
    end else if (o_eng_wr) begin
      case ((int'(o_eng_k) * int'(o_eng_n)) % 4)
        0:       acc_re <= acc_re + xv;
        1:       acc_im <= acc_im - xv;
        2:       acc_re <= acc_re - xv;
        default: acc_im <= acc_im + xv;
      endcase
      wr_seen <= wr_seen + 1;
    end
  end
  assign i_eng_X_re = acc_re[7:0];
  assign i_eng_X_im = acc_im[7:0];
  assign i_eng_done = done_en && (wr_seen != 0) && (wr_seen == int'(o_eng_N));

  // Engine-interface monitor: write pacing, index stepping, pulse counts.
  int cyc = 0, wr_pulses = 0, rst_pulses = 0, err_pulses = 0, last_wr_cyc = 0, prev_n = 0;
  bit saw_rst = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o_eng_reset) saw_rst <= 1'b1;
    if (o_eng_reset && !i_reset) rst_pulses <= rst_pulses + 1;
    if (o_err) err_pulses <= err_pulses + 1;
    if (o_eng_wr) begin
      chk("wr_rst_excl", int'(o_eng_reset), 0);
      if (o_eng_n == 8'd0) begin
        chk("rst_before_bin", int'(saw_rst), 1);
      end else begin
        chk("wr_spacing", cyc - last_wr_cyc, 16);
        chk("eng_n_step", int'(o_eng_n), prev_n + 1);
      end
      last_wr_cyc <= cyc;
      prev_n      <= int'(o_eng_n);
      wr_pulses   <= wr_pulses + 1;
      saw_rst     <= 1'b0;
    end
  end

  logic outs_any;
  assign outs_any = |{o_x_ready, o_eng_wr, o_eng_x, o_eng_k, o_eng_n, o_eng_N,
                      o_X_re, o_X_im, o_k, o_valid, o_busy, o_err};

  int xa[4] = '{0, 1, 0, 1};
  int xb[4] = '{3, 1, -2, 5};

  task automatic start_frame(input int n, input int kf, input int kc);
    i_start   = 1'b1;
    i_N       = 8'(n);
    i_k_first = 8'(kf);
    i_k_count = 8'(kc);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic load(input int xs[4]);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) chk("x_ready_load", int'(o_x_ready), 1);
      i_x       = 8'(xs[i]);
      i_x_valid = 1'b1;
      @(negedge clk);
    end
    i_x_valid = 1'b0;
    chk("x_ready_drop", int'(o_x_ready), 0);
  endtask

  task automatic get_result(output int k, output int re, output int im);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (o_valid) break;
    end
    chk("valid_seen", int'(o_valid), 1);
    k  = int'(o_k);
    re = int'($signed(o_X_re));
    im = int'($signed(o_X_im));
  endtask

  task automatic expect_result(input string tag, input int ek, input int ere, input int eim);
    int k, re, im;
    get_result(k, re, im);
    chk({tag, "_k"}, k, ek);
    chk({tag, "_re"}, re, ere);
    chk({tag, "_im"}, im, eim);
  endtask

  initial begin
    int snap_wr, snap_rst, snap_err, t_err;
    bit seen;
    i_reset = 1'b1; i_start = 1'b0; i_N = '0; i_k_first = '0; i_k_count = '0;
    i_x = '0; i_x_valid = 1'b0; i_ready = 1'b1; done_en = 1'b1;

    // Reset behaviour
    repeat (2) @(negedge clk);
    chk("rst_eng_reset", int'(o_eng_reset), 1);
    chk("rst_x_ready", int'(o_x_ready), 0);
    chk("rst_busy", int'(o_busy), 0);
    i_reset = 1'b0;
    #1;
    chk("post_rst_eng_reset", int'(o_eng_reset), 0);
    chk("post_rst_outs", int'(outs_any), 0);

    // Bad frame lengths
    @(negedge clk);
    i_start = 1'b1; i_N = 8'd0; i_k_count = 8'd1;
    @(negedge clk);
    i_start = 1'b0;
    chk("err_n0", int'(o_err), 1);
    chk("err_n0_idle", int'(o_busy), 0);
    @(negedge clk);
    chk("err_one_cycle", int'(o_err), 0);
    i_start = 1'b1; i_N = 8'd17;
    @(negedge clk);
    i_start = 1'b0;
    chk("err_nbig", int'(o_err), 1);
    chk("err_nbig_idle", int'(o_busy), 0);
    @(negedge clk);

    // Main frame; stray start and sample strobes while busy must be ignored
    snap_wr = wr_pulses; snap_rst = rst_pulses; snap_err = err_pulses;
    start_frame(4, 0, 4);
    chk("busy_load", int'(o_busy), 1);
    load(xa);
    i_x = 8'sd99; i_x_valid = 1'b1;
    i_start = 1'b1; i_N = 8'd0;
    @(negedge clk);
    i_start = 1'b0;
    expect_result("f1b0", 0, 2, 0);
    expect_result("f1b1", 1, 0, 0);
    expect_result("f1b2", 2, -2, 0);
    expect_result("f1b3", 3, 0, 0);
    i_x_valid = 1'b0;
    @(negedge clk);
    chk("f1_busy_end", int'(o_busy), 0);
    chk("f1_writes", wr_pulses - snap_wr, 16);
    chk("f1_eng_resets", rst_pulses - snap_rst, 4);
    chk("f1_no_err", err_pulses - snap_err, 0);

    // Zero bins: frame loads, nothing is computed
    start_frame(4, 0, 0);
    load(xa);
    chk("kc0_idle", int'(o_busy), 0);
    chk("kc0_no_eng", int'(o_eng_reset), 0);
    @(negedge clk);
    chk("kc0_no_valid", int'(o_valid), 0);

    // Wrapped bins with backpressure on the second result
    start_frame(4, 3, 3);
    load(xb);
    expect_result("wr0", 3, 5, -4);
    @(negedge clk);
    i_ready = 1'b0;
    expect_result("wr1", 0, 7, 0);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", int'(o_valid), 1);
      chk("bp_k", int'(o_k), 0);
      chk("bp_re", int'($signed(o_X_re)), 7);
      chk("bp_wr", int'(o_eng_wr), 0);
      chk("bp_eng_rst", int'(o_eng_reset), 0);
    end
    i_ready = 1'b1;
    expect_result("wr2", 1, 5, 4);
    @(negedge clk);
    chk("wr_busy_end", int'(o_busy), 0);

    // Engine never completes
    done_en = 1'b0;
    snap_wr = wr_pulses;
    start_frame(4, 0, 1);
    load(xa);
    seen = 1'b0; t_err = 0;
    for (int t = 0; t < 1500 && !seen; t++) begin
      @(negedge clk);
      if (o_err) begin
        seen  = 1'b1;
        t_err = cyc;
      end
    end
    chk("tmo_err", int'(seen), 1);
    chk("tmo_cycles", t_err - last_wr_cyc, 1040);
    chk("tmo_idle", int'(o_busy), 0);
    chk("tmo_writes", wr_pulses - snap_wr, 4);
    done_en = 1'b1;
    @(negedge clk);
    chk("tmo_err_pulse", int'(o_err), 0);

    // Reset during a write of the second bin, then a clean frame
    start_frame(4, 0, 4);
    load(xa);
    expect_result("rb0", 0, 2, 0);
    seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      if (o_eng_wr && o_eng_n == 8'd2) seen = 1'b1;
    end
    chk("feed_bin2_found", int'(seen), 1);
    #1 i_reset = 1'b1;
    #1;
    chk("rst_feed_no_wr", int'(o_eng_wr), 0);
    chk("rst_feed_eng_rst", int'(o_eng_reset), 1);
    @(negedge clk);
    chk("rst_feed_outs", int'(outs_any), 0);
    chk("rst_feed_hold_rst", int'(o_eng_reset), 1);
    i_reset = 1'b0;
    #1;
    chk("rst_feed_rel_outs", int'(outs_any), 0);
    chk("rst_feed_rel_rst", int'(o_eng_reset), 0);
    start_frame(4, 1, 2);
    load(xb);
    expect_result("nf0", 1, 5, 4);
    expect_result("nf1", 2, -5, 0);
    @(negedge clk);
    chk("nf_busy_end", int'(o_busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
